if_fetch_queue: RTL and testbench

Parametrised multi-wide instruction fetch unit with a decoupling instruction queue between instruction memory and decode. Each cycle it issues one fetch address and accepts FETCH_WIDTH consecutive instruction words from IM. Entries are buffered with their PCs in a circular queue, and decode removes up to FETCH_WIDTH entries per cycle. It also supports branch redirect with queue flush, and independent front-side (memory) and back-side (decode) stalls.

---
 rtl/if_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//
// Multi-wide instruction fetch front end. Each cycle it presents one fetch
// address to instruction memory and accepts FETCH_WIDTH consecutive words.
// The words and their PCs are buffered in a circular queue. Decode drains up
// to FETCH_WIDTH entries per cycle. A redirect flushes the queue and restarts
// fetch at Alt_PC.
//
// Handshake: a push happens on a rising edge when memory is ready (!stall_C)
// and the queue, after any flush, has at least FETCH_WIDTH free entries. The
// push does not count space that same-cycle pops would free. A pop of
// min(Pop_Count, count) entries happens on the same edge unless STALL or
// Request_Alt_PC is high.
//
// Ports:
//   CLK, RESET          clock (rising edge), async active-low reset
//   STALL               decode freeze, blocks pops
//   stall_C             memory not ready, blocks push and PC advance
//   Request_Alt_PC      redirect strobe, Alt_PC is the target
//   Pop_Count           entries decode consumes this cycle
//   Instr_fIM           FETCH_WIDTH words from IM, slot i at bits [32i+31:32i]
//   Instr_address_2IM   fetch address (only combinational input->output path)
//   Instr_OUT/_PC_OUT   oldest FETCH_WIDTH entries, slot 0 = head
//   Instr_Valid_OUT     thermometer, bit i set iff count > i
//   Queue_Count         occupied entries
//   Queue_Full          fewer than FETCH_WIDTH entries free
module if_fetch_queue #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'hBFC00000,
  localparam int         PCW         = $clog2(FETCH_WIDTH + 1),
  localparam int         CW          = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      STALL,
  input  logic                      stall_C,
  input  logic                      Request_Alt_PC,
  input  logic [31:0]               Alt_PC,
  input  logic [PCW-1:0]            Pop_Count,
  input  logic [32*FETCH_WIDTH-1:0] Instr_fIM,
  output logic [31:0]               Instr_address_2IM,
  output logic [32*FETCH_WIDTH-1:0] Instr_OUT,
  output logic [32*FETCH_WIDTH-1:0] Instr_PC_OUT,
  output logic [FETCH_WIDTH-1:0]    Instr_Valid_OUT,
  output logic [CW-1:0]             Queue_Count,
  output logic                      Queue_Full
);

  localparam int            AW   = $clog2(QUEUE_DEPTH);
  localparam logic [CW-1:0] FW_C = CW'(FETCH_WIDTH);
  localparam logic [CW-1:0] QD_C = CW'(QUEUE_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instr [QUEUE_DEPTH];
  logic [31:0]   r_pc    [QUEUE_DEPTH];

  logic [31:0]   w_addr;
  logic [CW-1:0] w_count_base;
  logic [AW-1:0] w_head_base;
  logic [AW-1:0] w_tail_base;
  logic [CW-1:0] w_free;
  logic          w_push;
  logic [CW-1:0] w_pop_req;
  logic [CW-1:0] w_pop_n;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_head_next;
  logic [AW-1:0] w_tail_next;
  logic [31:0]   w_fetch_pc_next;
  logic [AW-1:0] w_wr_idx [FETCH_WIDTH];

  assign w_addr = Request_Alt_PC ? Alt_PC : r_fetch_pc;

  always_comb begin
    // A redirect empties the queue before the push decision, so the
    // alternate path can be fetched in the same cycle.
    w_count_base = Request_Alt_PC ? '0 : r_count;
    w_head_base  = Request_Alt_PC ? '0 : r_head;
    w_tail_base  = Request_Alt_PC ? '0 : r_tail;
    w_free       = QD_C - w_count_base;
    w_push       = !stall_C && (w_free >= FW_C);

    // Requests beyond the current occupancy are clamped, never an error.
    w_pop_req = CW'(Pop_Count);
    if (Request_Alt_PC || STALL)
      w_pop_n = '0;
    else if (w_pop_req < r_count)
      w_pop_n = w_pop_req;
    else
      w_pop_n = r_count;

    w_count_next    = w_count_base - w_pop_n + (w_push ? FW_C : '0);
    w_head_next     = w_head_base + w_pop_n[AW-1:0];
    w_tail_next     = w_tail_base + (w_push ? AW'(FETCH_WIDTH) : '0);
    w_fetch_pc_next = w_push ? (w_addr + 32'(4 * FETCH_WIDTH)) : w_addr;

    for (int i = 0; i < FETCH_WIDTH; i++)
      w_wr_idx[i] = w_tail_base + AW'(i);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_fetch_pc <= RESET_PC;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else begin
      r_fetch_pc <= w_fetch_pc_next;
      r_head     <= w_head_next;
      r_tail     <= w_tail_next;
      r_count    <= w_count_next;
      if (w_push) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          r_instr[w_wr_idx[i]] <= Instr_fIM[32*i +: 32];
          r_pc[w_wr_idx[i]]    <= w_addr + 32'(4 * i);
        end
      end
    end
  end

  // Output slots read from the head and wrap around the storage. Slots past
  // the occupancy show whatever is stored; the valid bits tell decode.
  always_comb begin
    Instr_OUT       = '0;
    Instr_PC_OUT    = '0;
    Instr_Valid_OUT = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      Instr_OUT[32*i +: 32]    = r_instr[r_head + AW'(i)];
      Instr_PC_OUT[32*i +: 32] = r_pc[r_head + AW'(i)];
      Instr_Valid_OUT[i]       = r_count > CW'(i);
    end
  end

  assign Instr_address_2IM = w_addr;
  assign Queue_Count       = r_count;
  assign Queue_Full        = (QD_C - r_count) < FW_C;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int          FW       = 2;
  localparam int          QD       = 8;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic              RESET;
  logic              STALL;
  logic              stall_C;
  logic              Request_Alt_PC;
  logic [31:0]       Alt_PC;
  logic [1:0]        Pop_Count;
  logic [32*FW-1:0]  Instr_fIM;
  logic [31:0]       Instr_address_2IM;
  logic [32*FW-1:0]  Instr_OUT;
  logic [32*FW-1:0]  Instr_PC_OUT;
  logic [FW-1:0]     Instr_Valid_OUT;
  logic [3:0]        Queue_Count;
  logic              Queue_Full;

  if_fetch_queue #(.FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .stall_C(stall_C),
    .Request_Alt_PC(Request_Alt_PC), .Alt_PC(Alt_PC), .Pop_Count(Pop_Count),
    .Instr_fIM(Instr_fIM), .Instr_address_2IM(Instr_address_2IM),
    .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT),
    .Instr_Valid_OUT(Instr_Valid_OUT), .Queue_Count(Queue_Count),
    .Queue_Full(Queue_Full)
  );

  // scoreboard: reference queue of {instr, pc} plus reference fetch PC
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch_pc;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic [FW-1:0] v;
    sz = exp_q.size();
    v = '0;
    check("count", 64'(Queue_Count), 64'(sz));
    check("full", 64'(Queue_Full), 64'((QD - sz) < FW));
    for (int i = 0; i < FW; i++) if (i < sz) v[i] = 1'b1;
    check("valid", 64'(Instr_Valid_OUT), 64'(v));
    for (int i = 0; i < FW; i++) begin
      if (i < sz) begin
        check("slot_instr", 64'(Instr_OUT[32*i +: 32]), 64'(exp_q[i][63:32]));
        check("slot_pc", 64'(Instr_PC_OUT[32*i +: 32]), 64'(exp_q[i][31:0]));
      end
    end
  endtask

  // driver: one clock cycle, entered and left 1 time unit after a rising edge
  task automatic do_cycle(input logic stall, input logic stall_c, input logic redir,
                          input logic [31:0] alt, input int popc);
    logic [31:0] a;
    int base;
    int n;
    bit push;
    a = redir ? alt : m_fetch_pc;
    STALL = stall;
    stall_C = stall_c;
    Request_Alt_PC = redir;
    Alt_PC = alt;
    Pop_Count = popc[1:0];
    for (int i = 0; i < FW; i++) Instr_fIM[32*i +: 32] = im_word(a + 32'(4 * i));
    #1;
    check("addr", 64'(Instr_address_2IM), 64'(a));
    @(posedge CLK);
    if (redir) exp_q.delete();
    base = exp_q.size();
    push = !stall_c && ((QD - base) >= FW);
    if (!redir && !stall) begin
      n = (popc < base) ? popc : base;
      repeat (n) void'(exp_q.pop_front());
    end
    if (push) begin
      for (int i = 0; i < FW; i++)
        exp_q.push_back({im_word(a + 32'(4 * i)), a + 32'(4 * i)});
      m_fetch_pc = a + 32'(4 * FW);
    end else begin
      m_fetch_pc = a;
    end
    #1;
    check_outputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, 64'(Instr_OUT), 64'd0);
    check({tag, "_pc"}, 64'(Instr_PC_OUT), 64'd0);
    check({tag, "_valid"}, 64'(Instr_Valid_OUT), 64'd0);
    check({tag, "_count"}, 64'(Queue_Count), 64'd0);
    check({tag, "_full"}, 64'(Queue_Full), 64'd0);
    check({tag, "_addr"}, 64'(Instr_address_2IM), 64'(RESET_PC));
  endtask

  initial begin
    RESET = 1'b0;
    STALL = 1'b0;
    stall_C = 1'b0;
    Request_Alt_PC = 1'b0;
    Alt_PC = '0;
    Pop_Count = '0;
    Instr_fIM = '0;
    m_fetch_pc = RESET_PC;
    #12;
    check_reset_outputs("reset");
    RESET = 1'b1;

    // fill to full, then address holds at BFC00020
    repeat (4) do_cycle(0, 0, 0, 0, 0);
    check("fill_count", 64'(Queue_Count), 64'd8);
    check("fill_full", 64'(Queue_Full), 64'd1);
    repeat (2) do_cycle(0, 0, 0, 0, 0);
    check("full_hold_addr", 64'(m_fetch_pc), 64'h0000_0000_BFC0_0020);

    // pop to 6, then redirect
    do_cycle(0, 0, 0, 0, 2);
    check("pre_redir_count", 64'(Queue_Count), 64'd6);
    do_cycle(0, 0, 1, 32'h8000_1000, 0);
    check("redir_slot0_pc", 64'(Instr_PC_OUT[31:0]), 64'h8000_1000);
    check("redir_slot1_pc", 64'(Instr_PC_OUT[63:32]), 64'h8000_1004);
    check("redir_next_pc", 64'(m_fetch_pc), 64'h8000_1008);

    // streaming at peak rate (wraps head and tail several times)
    repeat (20) do_cycle(0, 0, 0, 0, 2);

    // memory stall holds address and count
    repeat (3) do_cycle(0, 1, 0, 0, 0);
    // decode freeze with Pop_Count=2 pops nothing
    do_cycle(1, 1, 0, 0, 2);
    // redirect overrides STALL pops
    do_cycle(1, 0, 1, 32'h0000_4000, 2);
    // get to count 1, then clamp a pop of 2
    do_cycle(0, 1, 0, 0, 1);
    do_cycle(0, 1, 0, 0, 2);
    check("clamp_valid", 64'(Instr_Valid_OUT), 64'd0);

    // redirect during memory stall, then release
    do_cycle(0, 1, 1, 32'h0000_2000, 0);
    do_cycle(0, 1, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0);
    check("post_stall_push_pc", 64'(Instr_PC_OUT[31:0]), 64'h2000);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic redir;
      redir = ($urandom_range(0, 15) == 0);
      do_cycle(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
               redir, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
               int'($urandom_range(0, FW)));
    end

    // build count 5, then asynchronous reset mid-cycle
    do_cycle(0, 0, 1, 32'h1234_5670, 0);
    do_cycle(0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1);
    check("pre_reset_count", 64'(Queue_Count), 64'd5);
    Request_Alt_PC = 1'b0;
    RESET = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    m_fetch_pc = RESET_PC;
    #1;
    RESET = 1'b1;
    do_cycle(0, 0, 0, 0, 0);
    check("restart_pc", 64'(Instr_PC_OUT[31:0]), 64'(RESET_PC));
    repeat (5) do_cycle(0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
